// File: rtl/regfile_op_sequencer.sv
// regfile_op_sequencer: runs one ALU operation over a single-port 16x8
// register unit. It reads two operands serially, starts the ALU, waits for
// completion or times out, and optionally writes the result back. It also
// arbitrates register-unit access between operation requests and an
// external write port, alternating between them when both are waiting.
//
// Handshake rule (both request ports): a transfer happens on a rising clock
// edge where valid and ready are both high. ready depends on valid only
// through the arbiter and is high only in IDLE, for at most one port at a
// time. The requester holds valid and its fields stable until that edge.
module regfile_op_sequencer #(
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 8,
  parameter int ALU_TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_rs1,
  input  logic [ADDR_W-1:0] req_rs2,
  input  logic [ADDR_W-1:0] req_rd,
  input  logic              req_wb,
  input  logic              ext_wr_valid,
  output logic              ext_wr_ready,
  input  logic [ADDR_W-1:0] ext_wr_addr,
  input  logic [DATA_W-1:0] ext_wr_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic              alu_start,
  input  logic              alu_done,
  input  logic [DATA_W-1:0] alu_result,
  output logic [ADDR_W-1:0] rf_addr,
  output logic              rf_load,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              err,
  output logic [2:0]        o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_EXT_WR = 3'd1,
    S_RD_A   = 3'd2,
    S_CAP_A  = 3'd3,
    S_CAP_B  = 3'd4,
    S_EXEC   = 3'd5,
    S_WB     = 3'd6,
    S_DONE   = 3'd7
  } state_t;

  typedef enum logic {
    RR_REQ = 1'b0,
    RR_EXT = 1'b1
  } rr_t;

  // Value of the EXEC cycle counter in the last cycle allowed before abort.
  localparam logic [7:0] LP_CNT_LAST = 8'(ALU_TIMEOUT - 1);

  state_t              r_state;
  state_t              w_state_next;
  rr_t                 r_rr_last;
  logic [ADDR_W-1:0]   r_rs1;
  logic [ADDR_W-1:0]   r_rs2;
  logic [ADDR_W-1:0]   r_rd;
  logic                r_wb;
  logic [ADDR_W-1:0]   r_ext_addr;
  logic [DATA_W-1:0]   r_ext_data;
  logic [DATA_W-1:0]   r_alu_a;
  logic [DATA_W-1:0]   r_alu_b;
  logic [DATA_W-1:0]   r_result;
  logic                r_err;
  logic [7:0]          r_cnt;

  logic                w_grant_req;
  logic                w_grant_ext;
  logic                w_acc_req;
  logic                w_acc_ext;
  logic                w_timeout;

  // Round-robin: with both sides waiting, the side not served last wins.
  assign w_grant_req = req_valid && (!ext_wr_valid || (r_rr_last == RR_EXT));
  assign w_grant_ext = ext_wr_valid && !w_grant_req;
  assign w_acc_req   = (r_state == S_IDLE) && w_grant_req;
  assign w_acc_ext   = (r_state == S_IDLE) && w_grant_ext;
  assign w_timeout   = (r_cnt == LP_CNT_LAST);

  assign alu_a       = r_alu_a;
  assign alu_b       = r_alu_b;
  assign result      = r_result;
  assign err         = r_err;
  assign o_dbg_state = r_state;

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and register-unit / handshake outputs.
  always_comb begin
    w_state_next = r_state;
    req_ready    = 1'b0;
    ext_wr_ready = 1'b0;
    rf_addr      = '0;
    rf_load      = 1'b0;
    rf_wdata     = '0;
    alu_start    = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready    = w_grant_req;
        ext_wr_ready = w_grant_ext;
        if (w_grant_req) begin
          w_state_next = S_RD_A;
        end else if (w_grant_ext) begin
          w_state_next = S_EXT_WR;
        end
      end
      S_EXT_WR: begin
        rf_addr      = r_ext_addr;
        rf_wdata     = r_ext_data;
        rf_load      = 1'b1;
        w_state_next = S_IDLE;
      end
      S_RD_A: begin
        // rs1 held across this edge; its data is sampled one edge later.
        rf_addr      = r_rs1;
        w_state_next = S_CAP_A;
      end
      S_CAP_A: begin
        rf_addr      = r_rs2;
        w_state_next = S_CAP_B;
      end
      S_CAP_B: begin
        rf_addr      = r_rs2;
        w_state_next = S_EXEC;
      end
      S_EXEC: begin
        alu_start = (r_cnt == 8'd0);
        if (alu_done) begin
          w_state_next = r_wb ? S_WB : S_DONE;
        end else if (w_timeout) begin
          w_state_next = S_DONE;
        end
      end
      S_WB: begin
        rf_addr      = r_rd;
        rf_wdata     = r_result;
        rf_load      = 1'b1;
        w_state_next = S_DONE;
      end
      S_DONE: begin
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Datapath: latch fields at accept, capture operands, track EXEC cycles.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rr_last  <= RR_EXT;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_wb       <= 1'b0;
      r_ext_addr <= '0;
      r_ext_data <= '0;
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_result   <= '0;
      r_err      <= 1'b0;
      r_cnt      <= '0;
    end else begin
      if (w_acc_req) begin
        r_rs1     <= req_rs1;
        r_rs2     <= req_rs2;
        r_rd      <= req_rd;
        r_wb      <= req_wb;
        r_rr_last <= RR_REQ;
        r_err     <= 1'b0;
        r_cnt     <= '0;
      end
      if (w_acc_ext) begin
        r_ext_addr <= ext_wr_addr;
        r_ext_data <= ext_wr_data;
        r_rr_last  <= RR_EXT;
        r_err      <= 1'b0;
      end
      case (r_state)
        S_CAP_A: r_alu_a <= rf_rdata;
        S_CAP_B: r_alu_b <= rf_rdata;
        S_EXEC: begin
          r_cnt <= r_cnt + 8'd1;
          // A completion in the last allowed cycle still counts as success.
          if (alu_done) begin
            r_result <= alu_result;
          end else if (w_timeout) begin
            r_err <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/regfile_op_sequencer.md
Name: regfile_op_sequencer

Overview:
- Sequences ALU operations over the single-port 16x8 register unit: fetches two operands serially, hands them to the ALU, waits for completion, and writes the result back.
- Arbitrates register-unit access between the operation requester and an external write port (loader/debug) with round-robin fairness.
- Sits between the control unit, the ALU and the register unit; it is the only driver of the register unit's addr/load/data_in.

Parameters:
- ADDR_W, 4, register address width (16 slots)
- DATA_W, 8, register data width
- ALU_TIMEOUT, 15, max EXEC cycles waiting for alu_done before abort (1..255)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  operation request
- req_ready  out  1  request accepted when valid&ready at clock edge
- req_rs1  in  ADDR_W  operand A register
- req_rs2  in  ADDR_W  operand B register
- req_rd  in  ADDR_W  destination register
- req_wb  in  1  1 = write result to rd; 0 = result only (compare ops)
- ext_wr_valid  in  1  external write request
- ext_wr_ready  out  1  external write accepted when valid&ready
- ext_wr_addr  in  ADDR_W  external write address
- ext_wr_data  in  DATA_W  external write data
- alu_a, alu_b  out  DATA_W  captured operands, held stable EXEC..DONE
- alu_start  out  1  one-cycle pulse, first EXEC cycle
- alu_done  in  1  ALU result valid
- alu_result  in  DATA_W  ALU result
- rf_addr  out  ADDR_W  to register unit addr
- rf_load  out  1  to register unit load
- rf_wdata  out  DATA_W  to register unit data_in
- rf_rdata  in  DATA_W  from register unit data_out
- done  out  1  one-cycle pulse, operation complete
- result  out  DATA_W  latched ALU result, valid from done until next done
- err  out  1  set with done on ALU timeout; cleared at next accept

Behaviour:
- Reset (async): state IDLE; all outputs 0; rr_last=EXT (request has first priority); timeout counter 0. Reset mid-operation aborts: no rf_load, no done.
- Register-unit timing: rf_addr held across edge E; rf_rdata sampled at edge E+1. rf_load asserted only in WB and EXT_WR.
- States: IDLE, EXT_WR, RD_A, CAP_A, CAP_B, EXEC, WB, DONE.
- IDLE: req_ready and ext_wr_ready driven combinationally from arbitration; both 0 outside IDLE. Only one asserted at a time. Both valid -> grant the side not granted last (rr_last); one valid -> grant it. Request fields/ext fields latched at accept.
- EXT_WR (1 cycle): rf_addr=ext addr, rf_wdata=ext data, rf_load=1; rr_last=EXT; -> IDLE.
- RD_A: rf_addr=rs1 -> CAP_A. CAP_A: rf_addr=rs2; capture alu_a<=rf_rdata at exit -> CAP_B. CAP_B: capture alu_b<=rf_rdata at exit -> EXEC. rr_last=REQ at accept.
- EXEC: alu_start=1 first cycle only; counter increments each EXEC cycle; alu_done (may coincide with alu_start) -> result<=alu_result, then WB if req_wb else DONE. Counter reaching ALU_TIMEOUT without alu_done -> err=1, DONE, no writeback.
- WB (1 cycle): rf_addr=rd, rf_wdata=result, rf_load=1 -> DONE.
- DONE (1 cycle): done=1 -> IDLE.
- Latency (req_wb=1, alu_done in first EXEC cycle): accept edge 0; done high in cycle 6. New request acceptable cycle 7.
- rs1=rs2 and rd=rs1/rs2 legal; operands captured before WB, so no hazard.

Test Plan:
- Reset with reset asserted mid-EXEC -> all outputs 0 immediately, state IDLE, no rf_load pulse observed.
- Ext write r3=0x05, r7=0x0A; request rs1=3 rs2=7 rd=9 wb=1, ALU adds -> alu_a=0x05, alu_b=0x0A, alu_start one pulse, rf_load with addr 9 data 0x0F, done at cycle 6, reading r9 returns 0x0F.
- req_valid and ext_wr_valid held continuously for 4 grants -> grants alternate REQ, EXT, REQ, EXT; never both ready in one cycle.
- Request wb=0, rs1=rs2=3 (0x05), ALU subtract -> result=0x00, done pulse, no rf_load during operation.
- alu_done never asserted, ALU_TIMEOUT=15 -> 15 EXEC cycles, then done=1 with err=1, rd unchanged; next accept clears err.
- ALU delays alu_done 3 cycles, rd=rs1=4 (0xFF+0x01) -> r4=0x00 after WB, alu_a stays 0xFF until done.
